// File: rtl/adder_fifo_pkg.sv
// adder_fifo_pkg: shared widths and types for the multi-channel adder datapath
package adder_fifo_pkg;
  typedef logic [15:0] stats_cnt_t;
  function automatic int out_width(input int data_w, input int n_ch);
    return data_w + $clog2(n_ch);
  endfunction
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/multi_adder_fifo_sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers, combinational head read and flush
module sync_fifo
  import adder_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push_ready = !((wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
  assign pop_valid = wr_ptr != rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign push = push_valid && push_ready;
  assign pop = pop_valid && pop_ready;
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/multi_adder_fifo.sv
// multi_adder_fifo: N-channel FIFO-buffered adder join; ADDER_FIFO_STATS_EN adds txn_count and drop_flag
module multi_adder_fifo
  import adder_fifo_pkg::*;
#(
  parameter int DATA_IN_WIDTH = 8,
  parameter int N_CH = 4,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4,
  localparam int OUT_WIDTH = out_width(DATA_IN_WIDTH, N_CH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [N_CH-1:0][DATA_IN_WIDTH-1:0]  ch_in,
  input  logic [N_CH-1:0]                     ch_in_valid,
  output logic [N_CH-1:0]                     ch_in_ready,
  output logic [OUT_WIDTH-1:0]                out,
  output logic                                out_valid,
  input  logic                                out_ready
`ifdef ADDER_FIFO_STATS_EN
  ,
  output stats_cnt_t                          txn_count,
  output logic                                drop_flag
`endif
);
  logic [N_CH-1:0][DATA_IN_WIDTH-1:0] heads;
  logic [N_CH-1:0] heads_valid;
  logic [OUT_WIDTH-1:0] sum_d, sum_q;
  logic sum_valid, out_push_ready, fire;
  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_in
      sync_fifo #(.DATA_WIDTH(DATA_IN_WIDTH), .DEPTH(IN_DEPTH)) u_in (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .push_valid(ch_in_valid[i]),
        .push_ready(ch_in_ready[i]),
        .push_data(ch_in[i]),
        .pop_valid(heads_valid[i]),
        .pop_ready(fire),
        .pop_data(heads[i])
      );
    end
  endgenerate
  assign fire = (&heads_valid) && (!sum_valid || out_push_ready);
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_CH; k++) sum_d = sum_d + OUT_WIDTH'(heads[k]);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) sum_valid <= 1'b0;
    else sum_valid <= fire || (sum_valid && !out_push_ready);
  end
  always_ff @(posedge clk_i) begin
    if (fire) sum_q <= sum_d;
  end
  sync_fifo #(.DATA_WIDTH(OUT_WIDTH), .DEPTH(OUT_DEPTH)) u_out (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .push_valid(sum_valid),
    .push_ready(out_push_ready),
    .push_data(sum_q),
    .pop_valid(out_valid),
    .pop_ready(out_ready),
    .pop_data(out)
  );
`ifdef ADDER_FIFO_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_count <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (out_valid && out_ready && !flush_i) txn_count <= txn_count + 1'b1;
      if (flush_i && (sum_valid || out_valid || (|heads_valid))) drop_flag <= 1'b1;
    end
  end
`endif
endmodule
